// File: rtl/interupt_request_controller_if.sv
// Signal bundle between the interrupt controller and its peripherals/CPU.
// The controller takes the slave modport; the peripheral/CPU side takes master.
interface interupt_request_controller_if #(
  parameter int NUM_SOURCES = 8,
  parameter int ID_WIDTH    = 3
);
  // Handshake: interupt_signal is a one-cycle pulse with irq_id valid from
  // that pulse until return_from_isr. The CPU answers with a one-cycle
  // return_from_isr, which is honoured only while an ISR is outstanding.
  logic [NUM_SOURCES-1:0] irq_in;
  logic                   mask_wr_en;
  logic [NUM_SOURCES-1:0] mask_wr_data;
  logic                   overrun_clr;
  logic                   return_from_isr;
  logic                   interupt_signal;
  logic [ID_WIDTH-1:0]    irq_id;
  logic                   in_service;
  logic [NUM_SOURCES-1:0] pending;
  logic [NUM_SOURCES-1:0] irq_mask;
  logic [NUM_SOURCES-1:0] overrun;
  logic [1:0]             dbg_state;

  modport master (
    output irq_in,
    output mask_wr_en,
    output mask_wr_data,
    output overrun_clr,
    output return_from_isr,
    input  interupt_signal,
    input  irq_id,
    input  in_service,
    input  pending,
    input  irq_mask,
    input  overrun,
    input  dbg_state
  );

  modport slave (
    input  irq_in,
    input  mask_wr_en,
    input  mask_wr_data,
    input  overrun_clr,
    input  return_from_isr,
    output interupt_signal,
    output irq_id,
    output in_service,
    output pending,
    output irq_mask,
    output overrun,
    output dbg_state
  );
endinterface

// File: rtl/interupt_request_controller.sv
// Edge-latching interrupt controller: pending/mask/overrun registers, fixed
// lowest-index-first priority, one outstanding ISR at a time.
module interupt_request_controller #(
  parameter int NUM_SOURCES = 8,
  parameter int ID_WIDTH    = 3
) (
  input logic                          clk,
  input logic                          reset,
  interupt_request_controller_if.slave bus
);

  // dbg_state encoding: 0 = IDLE, 1 = SIGNAL, 2 = IN_SERVICE
  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_SIGNAL     = 2'd1,
    ST_IN_SERVICE = 2'd2
  } state_t;

  state_t                 r_state;
  state_t                 w_state_next;

  logic [NUM_SOURCES-1:0] r_irq_in_d;
  logic [NUM_SOURCES-1:0] r_pending;
  logic [NUM_SOURCES-1:0] r_mask;
  logic [NUM_SOURCES-1:0] r_overrun;
  logic [ID_WIDTH-1:0]    r_irq_id;

  logic [NUM_SOURCES-1:0] w_rise;
  logic [NUM_SOURCES-1:0] w_eligible;
  logic [NUM_SOURCES-1:0] w_grant_clr;
  logic [NUM_SOURCES-1:0] w_overrun_set;
  logic [NUM_SOURCES-1:0] w_pending_next;
  logic [NUM_SOURCES-1:0] w_overrun_next;
  logic [ID_WIDTH-1:0]    w_winner;
  logic                   w_any_eligible;
  logic                   w_grant;
  logic                   w_interupt_signal;
  logic                   w_in_service;

  assign w_rise         = bus.irq_in & ~r_irq_in_d;
  assign w_eligible     = r_pending & r_mask;
  assign w_any_eligible = |w_eligible;
  assign w_grant        = (r_state == ST_IDLE) && w_any_eligible;

  // Scan from the top down so the lowest eligible index is the last to win.
  always_comb begin
    w_winner = '0;
    for (int i = NUM_SOURCES - 1; i >= 0; i--) begin
      if (w_eligible[i]) begin
        w_winner = ID_WIDTH'(i);
      end
    end
  end

  always_comb begin
    w_grant_clr = '0;
    for (int i = 0; i < NUM_SOURCES; i++) begin
      w_grant_clr[i] = w_grant && (w_winner == ID_WIDTH'(i));
    end
  end

  // A new edge always wins over the grant clear, so a request arriving on the
  // cycle its previous one is granted is kept rather than lost.
  assign w_overrun_set  = w_rise & r_pending & ~w_grant_clr;
  assign w_pending_next = (r_pending & ~w_grant_clr) | w_rise;
  assign w_overrun_next = (bus.overrun_clr ? '0 : r_overrun) | w_overrun_set;

  // FSM: state register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // FSM: next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_any_eligible) begin
          w_state_next = ST_SIGNAL;
        end
      end
      ST_SIGNAL: begin
        w_state_next = ST_IN_SERVICE;
      end
      ST_IN_SERVICE: begin
        if (bus.return_from_isr) begin
          w_state_next = ST_IDLE;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // FSM: outputs decoded straight from the state register
  always_comb begin
    w_interupt_signal = 1'b0;
    w_in_service      = 1'b0;
    case (r_state)
      ST_SIGNAL: begin
        w_interupt_signal = 1'b1;
        w_in_service      = 1'b1;
      end
      ST_IN_SERVICE: begin
        w_in_service = 1'b1;
      end
      default: begin
        w_interupt_signal = 1'b0;
        w_in_service      = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_irq_in_d <= '0;
      r_pending  <= '0;
      r_mask     <= '0;
      r_overrun  <= '0;
      r_irq_id   <= '0;
    end else begin
      r_irq_in_d <= bus.irq_in;
      r_pending  <= w_pending_next;
      r_overrun  <= w_overrun_next;
      if (bus.mask_wr_en) begin
        r_mask <= bus.mask_wr_data;
      end
      if (w_grant) begin
        r_irq_id <= w_winner;
      end
    end
  end

  assign bus.interupt_signal = w_interupt_signal;
  assign bus.in_service      = w_in_service;
  assign bus.irq_id          = r_irq_id;
  assign bus.pending         = r_pending;
  assign bus.irq_mask        = r_mask;
  assign bus.overrun         = r_overrun;
  assign bus.dbg_state       = r_state;

endmodule

// File: tb/tb_interupt_request_controller.sv
// Bench for interupt_request_controller: cycle table plus hand sequences,
// with a pulse scoreboard keyed on the expected irq_id.
module tb_interupt_request_controller;
  localparam int NS = 8;
  localparam int IW = 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  interupt_request_controller_if #(.NUM_SOURCES(NS), .ID_WIDTH(IW)) bus();

  interupt_request_controller #(.NUM_SOURCES(NS), .ID_WIDTH(IW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [NS-1:0] irq;
    logic          mwe;
    logic [NS-1:0] mwd;
    logic          oclr;
    logic          ret;
    logic [NS-1:0] e_pend;
    logic          e_sig;
    logic          e_isv;
    logic [IW-1:0] e_id;
    logic [NS-1:0] e_mask;
    logic [NS-1:0] e_ov;
  } vec_t;

  vec_t          vecs[$];
  logic [IW-1:0] exp_q[$];
  logic [IW-1:0] mon_exp;
  int            n_tests  = 0;
  int            n_fail   = 0;
  int            n_pulses = 0;

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [NS-1:0] irq, input logic mwe, input logic [NS-1:0] mwd,
                       input logic oclr, input logic ret);
    bus.irq_in          = irq;
    bus.mask_wr_en      = mwe;
    bus.mask_wr_data    = mwd;
    bus.overrun_clr     = oclr;
    bus.return_from_isr = ret;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic add_vec(input logic [NS-1:0] irq, input logic mwe, input logic [NS-1:0] mwd,
                         input logic oclr, input logic ret, input logic [NS-1:0] e_pend,
                         input logic e_sig, input logic e_isv, input logic [IW-1:0] e_id,
                         input logic [NS-1:0] e_mask, input logic [NS-1:0] e_ov);
    vec_t v;
    v = '{irq, mwe, mwd, oclr, ret, e_pend, e_sig, e_isv, e_id, e_mask, e_ov};
    vecs.push_back(v);
  endtask

  // ---------------- scoreboard on the pulse ----------------
  always @(negedge clk) begin
    if (bus.interupt_signal === 1'b1) begin
      n_pulses++;
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL pulse_unexpected: got pulse with irq_id %0d, expected no pulse", bus.irq_id);
      end else begin
        mon_exp = exp_q.pop_front();
        if (bus.irq_id !== mon_exp) begin
          n_fail++;
          $display("FAIL pulse_id: got irq_id %0d, expected %0d", bus.irq_id, mon_exp);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    vec_t v;
    int   p0;
    int   rt;

    //        irq   mwe mwd   oc ret  pend  sig isv id mask  ov
    add_vec(8'h00, 1, 8'hFF, 0, 0, 8'h00, 0, 0, 0, 8'hFF, 8'h00); // 0 enable all
    add_vec(8'h08, 0, 8'h00, 0, 0, 8'h08, 0, 0, 0, 8'hFF, 8'h00); // 1 rise on 3
    add_vec(8'h00, 0, 8'h00, 0, 0, 8'h00, 1, 1, 3, 8'hFF, 8'h00); // 2 pulse id 3
    add_vec(8'h00, 0, 8'h00, 0, 0, 8'h00, 0, 1, 3, 8'hFF, 8'h00);
    add_vec(8'h00, 0, 8'h00, 0, 0, 8'h00, 0, 1, 3, 8'hFF, 8'h00);
    add_vec(8'h00, 0, 8'h00, 0, 1, 8'h00, 0, 0, 3, 8'hFF, 8'h00); // 5 return
    add_vec(8'h00, 0, 8'h00, 0, 0, 8'h00, 0, 0, 3, 8'hFF, 8'h00);
    add_vec(8'h24, 0, 8'h00, 0, 0, 8'h24, 0, 0, 3, 8'hFF, 8'h00); // 7 rise on 5 and 2
    add_vec(8'h00, 0, 8'h00, 0, 0, 8'h20, 1, 1, 2, 8'hFF, 8'h00); // 8 id 2 wins
    add_vec(8'h00, 0, 8'h00, 0, 0, 8'h20, 0, 1, 2, 8'hFF, 8'h00);
    add_vec(8'h00, 0, 8'h00, 0, 0, 8'h20, 0, 1, 2, 8'hFF, 8'h00); // held off
    add_vec(8'h00, 0, 8'h00, 0, 1, 8'h20, 0, 0, 2, 8'hFF, 8'h00); // 11 return edge
    add_vec(8'h00, 0, 8'h00, 0, 0, 8'h00, 1, 1, 5, 8'hFF, 8'h00); // 12 second pulse
    add_vec(8'h00, 0, 8'h00, 0, 0, 8'h00, 0, 1, 5, 8'hFF, 8'h00);
    add_vec(8'h00, 0, 8'h00, 0, 1, 8'h00, 0, 0, 5, 8'hFF, 8'h00);
    add_vec(8'h00, 0, 8'h00, 0, 1, 8'h00, 0, 0, 5, 8'hFF, 8'h00); // 15 spurious return
    add_vec(8'h01, 0, 8'h00, 0, 0, 8'h01, 0, 0, 5, 8'hFF, 8'h00);
    add_vec(8'h00, 0, 8'h00, 0, 1, 8'h00, 1, 1, 0, 8'hFF, 8'h00); // 17 return in IDLE ignored
    add_vec(8'h00, 0, 8'h00, 0, 1, 8'h00, 0, 1, 0, 8'hFF, 8'h00); // 18 return in SIGNAL ignored
    add_vec(8'h00, 0, 8'h00, 0, 1, 8'h00, 0, 0, 0, 8'hFF, 8'h00);
    add_vec(8'h00, 0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 8'hFF, 8'h00);
    add_vec(8'h40, 1, 8'hBF, 0, 0, 8'h40, 0, 0, 0, 8'hBF, 8'h00); // 21 bit 6 masked
    add_vec(8'h00, 0, 8'h00, 0, 0, 8'h40, 0, 0, 0, 8'hBF, 8'h00);
    add_vec(8'h00, 1, 8'hFF, 0, 0, 8'h40, 0, 0, 0, 8'hFF, 8'h00); // 23 unmask
    add_vec(8'h40, 0, 8'h00, 0, 0, 8'h40, 1, 1, 6, 8'hFF, 8'h00); // 24 grant + rise: set wins
    add_vec(8'h00, 0, 8'h00, 0, 0, 8'h40, 0, 1, 6, 8'hFF, 8'h00);
    add_vec(8'h00, 0, 8'h00, 0, 1, 8'h40, 0, 0, 6, 8'hFF, 8'h00);
    add_vec(8'h00, 0, 8'h00, 0, 0, 8'h00, 1, 1, 6, 8'hFF, 8'h00);
    add_vec(8'h00, 0, 8'h00, 0, 0, 8'h00, 0, 1, 6, 8'hFF, 8'h00);
    add_vec(8'h00, 0, 8'h00, 0, 1, 8'h00, 0, 0, 6, 8'hFF, 8'h00);

    // reset state
    drive(8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
    reset = 1'b1;
    step();
    step();
    chk("reset_pending", 32'(bus.pending), 'h0);
    chk("reset_mask", 32'(bus.irq_mask), 'h0);
    chk("reset_overrun", 32'(bus.overrun), 'h0);
    chk("reset_irq_id", 32'(bus.irq_id), 'h0);
    chk("reset_signal", 32'(bus.interupt_signal), 'h0);
    chk("reset_in_service", 32'(bus.in_service), 'h0);
    chk("reset_state", 32'(bus.dbg_state), 'h0);
    reset = 1'b0;

    // table-driven cycles
    foreach (vecs[i]) begin
      v = vecs[i];
      drive(v.irq, v.mwe, v.mwd, v.oclr, v.ret);
      if (v.e_sig) exp_q.push_back(v.e_id);
      step();
      chk($sformatf("vec%0d_pending", i), 32'(bus.pending), 32'(v.e_pend));
      chk($sformatf("vec%0d_signal", i), 32'(bus.interupt_signal), 32'(v.e_sig));
      chk($sformatf("vec%0d_in_service", i), 32'(bus.in_service), 32'(v.e_isv));
      chk($sformatf("vec%0d_irq_id", i), 32'(bus.irq_id), 32'(v.e_id));
      chk($sformatf("vec%0d_mask", i), 32'(bus.irq_mask), 32'(v.e_mask));
      chk($sformatf("vec%0d_overrun", i), 32'(bus.overrun), 32'(v.e_ov));
    end

    // masked request fires two edges after the enabling mask write
    drive(8'h00, 1'b1, 8'h00, 1'b0, 1'b0);
    step();
    chk("mask_cleared", 32'(bus.irq_mask), 'h0);
    drive(8'h02, 1'b0, 8'h00, 1'b0, 1'b0);
    step();
    chk("mask_pending_set", 32'(bus.pending), 'h02);
    drive(8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
    p0 = n_pulses;
    repeat (10) step();
    chk("mask_no_pulse", 32'(n_pulses - p0), 'h0);
    chk("mask_still_pending", 32'(bus.pending), 'h02);
    chk("mask_idle", 32'(bus.in_service), 'h0);
    drive(8'h00, 1'b1, 8'h02, 1'b0, 1'b0);
    step();
    chk("mask_write_edge_signal", 32'(bus.interupt_signal), 'h0);
    chk("mask_write_value", 32'(bus.irq_mask), 'h02);
    drive(8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
    exp_q.push_back(3'd1);
    step();
    chk("mask_pulse", 32'(bus.interupt_signal), 'h1);
    chk("mask_pulse_id", 32'(bus.irq_id), 'h1);
    step();
    drive(8'h00, 1'b0, 8'h00, 1'b0, 1'b1);
    step();
    drive(8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
    chk("mask_returned", 32'(bus.in_service), 'h0);

    // overrun while masked, set beats clear, then plain clear
    drive(8'h10, 1'b0, 8'h00, 1'b0, 1'b0);
    step();
    chk("ovr_pending", 32'(bus.pending), 'h10);
    chk("ovr_first_edge", 32'(bus.overrun), 'h0);
    drive(8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
    step();
    drive(8'h10, 1'b0, 8'h00, 1'b0, 1'b0);
    step();
    chk("ovr_second_edge", 32'(bus.overrun), 'h10);
    drive(8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
    step();
    drive(8'h10, 1'b0, 8'h00, 1'b1, 1'b0);
    step();
    chk("ovr_set_beats_clear", 32'(bus.overrun), 'h10);
    drive(8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
    step();
    chk("ovr_hold", 32'(bus.overrun), 'h10);
    drive(8'h00, 1'b0, 8'h00, 1'b1, 1'b0);
    step();
    chk("ovr_cleared", 32'(bus.overrun), 'h0);
    drive(8'h00, 1'b1, 8'h10, 1'b0, 1'b0);
    step();
    exp_q.push_back(3'd4);
    drive(8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
    step();
    chk("ovr_pulse_id", 32'(bus.irq_id), 'h4);
    step();
    drive(8'h00, 1'b0, 8'h00, 1'b0, 1'b1);
    step();
    drive(8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
    step();
    chk("ovr_done_pending", 32'(bus.pending), 'h0);

    // level-held line counts as a single request
    drive(8'h00, 1'b1, 8'hFF, 1'b0, 1'b0);
    step();
    p0 = n_pulses;
    rt = $urandom_range(5, 15);
    exp_q.push_back(3'd0);
    for (int i = 0; i < 20; i++) begin
      drive(8'h01, 1'b0, 8'h00, 1'b0, (i == rt));
      step();
    end
    drive(8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
    chk("level_one_pulse", 32'(n_pulses - p0), 'h1);
    chk("level_pending", 32'(bus.pending), 'h0);
    chk("level_idle", 32'(bus.in_service), 'h0);

    // reset while IN_SERVICE with more requests pending
    drive(8'h02, 1'b0, 8'h00, 1'b0, 1'b0);
    step();
    exp_q.push_back(3'd1);
    drive(8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
    step();
    step();
    drive(8'h81, 1'b0, 8'h00, 1'b0, 1'b0);
    step();
    chk("rst_pre_pending", 32'(bus.pending), 'h81);
    chk("rst_pre_state", 32'(bus.dbg_state), 'h2);
    reset = 1'b1;
    step();
    chk("rst_in_service", 32'(bus.in_service), 'h0);
    chk("rst_pending", 32'(bus.pending), 'h0);
    chk("rst_mask", 32'(bus.irq_mask), 'h0);
    chk("rst_irq_id", 32'(bus.irq_id), 'h0);
    chk("rst_state", 32'(bus.dbg_state), 'h0);
    reset = 1'b0;
    step();
    chk("rst_held_line_edge", 32'(bus.pending), 'h81);
    p0 = n_pulses;
    repeat (10) step();
    chk("rst_no_pulse", 32'(n_pulses - p0), 'h0);
    chk("rst_stays_idle", 32'(bus.in_service), 'h0);

    chk("scoreboard_drain", 32'(exp_q.size()), 'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
